// File: rtl/packet_credit_arbiter.sv
// Round-robin wormhole arbiter for five ports (N,E,W,S,L) feeding one credit-managed output.
// Optional forced release of a stalled owner is built when ARB_TIMEOUT_EN is defined.
module packet_credit_arbiter #(
    parameter int CREDIT_DEPTH = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [4:0]                          req,
    input  logic [4:0]                          tail,
    input  logic                                credit_in,
    output logic [4:0]                          grant,
    output logic [4:0]                          xbar_sel,
    output logic [$clog2(CREDIT_DEPTH+1)-1:0]   credits,
    output logic                                credit_err,
    output logic                                timeout_err
);

    // state  | meaning
    // IDLE   | no owner; round-robin search over req from ptr+1
    // LOCKED | owner holds the output until its tail flit transfers
    typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

    localparam int CW = $clog2(CREDIT_DEPTH+1);
    localparam logic [CW-1:0] CMAX = CW'(CREDIT_DEPTH);

    state_t        state, state_nxt;
    logic [2:0]    owner, owner_nxt;
    logic [2:0]    ptr, ptr_nxt;
    logic [CW-1:0] credits_nxt;
    logic          credit_err_nxt;
    logic          grant_any;
    logic          to_hit;

    function automatic logic [2:0] rr_pick(input logic [4:0] r, input logic [2:0] p);
        logic [3:0] sum;
        logic       found;
        rr_pick = p;
        found   = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            sum = {1'b0, p} + 4'(i);
            if (sum >= 4'd5) sum = sum - 4'd5;
            if (!found && r[sum[2:0]]) begin
                rr_pick = sum[2:0];
                found   = 1'b1;
            end
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 3'd0;
            ptr        <= 3'd3;
            credits    <= CMAX;
            credit_err <= 1'b0;
        end else begin
            state      <= state_nxt;
            owner      <= owner_nxt;
            ptr        <= ptr_nxt;
            credits    <= credits_nxt;
            credit_err <= credit_err_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (|req) begin
                    state_nxt = LOCKED;
                    owner_nxt = rr_pick(req, ptr);
                end
            end
            LOCKED: begin
                if ((grant_any && tail[owner]) || to_hit) begin
                    state_nxt = IDLE;
                    ptr_nxt   = owner;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant    = 5'b00000;
        xbar_sel = 5'b00000;
        if (state == LOCKED) begin
            xbar_sel = 5'b00001 << owner;
            if (req[owner] && (credits != '0)) grant = 5'b00001 << owner;
        end
    end

    assign grant_any = |grant;

    // A return at full count with nothing consumed is dropped and flagged.
    always_comb begin
        credits_nxt    = credits;
        credit_err_nxt = 1'b0;
        if (credit_in && !grant_any) begin
            if (credits == CMAX) credit_err_nxt = 1'b1;
            else                 credits_nxt    = credits + 1'b1;
        end else if (!credit_in && grant_any) begin
            credits_nxt = credits - 1'b1;
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT+1);
    logic [TW-1:0] to_cnt, to_cnt_nxt;

    assign to_hit = (state == LOCKED) && !grant_any && (to_cnt == TW'(TIMEOUT-1));

    always_comb begin
        to_cnt_nxt = to_cnt;
        if ((state_nxt != state) || grant_any) to_cnt_nxt = '0;
        else if (state == LOCKED)              to_cnt_nxt = to_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            to_cnt      <= to_cnt_nxt;
            timeout_err <= to_hit;
        end
    end
`else
    assign to_hit      = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_packet_credit_arbiter.sv
// Directed bench for packet_credit_arbiter: allocation order, credit flow, lock hold and reset.
module tb_packet_credit_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] req, tail;
    logic       credit_in;
    logic [4:0] grant, xbar_sel;
    logic [2:0] credits;
    logic       credit_err, timeout_err;

    int checks   = 0;
    int failures = 0;

    packet_credit_arbiter #(.CREDIT_DEPTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst), .req(req), .tail(tail), .credit_in(credit_in),
        .grant(grant), .xbar_sel(xbar_sel), .credits(credits),
        .credit_err(credit_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 5'b0; tail = 5'b0; credit_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_grant",   32'(grant), 32'h00);
        check("rst_xbar",    32'(xbar_sel), 32'h00);
        check("rst_credits", 32'(credits), 32'd4);
        check("rst_cerr",    32'(credit_err), 32'd0);
        check("rst_terr",    32'(timeout_err), 32'd0);
        rst = 1'b0;

        req = 5'b10001;
        #1 check("idle_no_grant", 32'(grant), 32'h00);
        tick;
        check("lock_L_xbar",  32'(xbar_sel), 32'h10);
        check("lock_L_grant", 32'(grant), 32'h10);
        tick;
        check("flit1_credits", 32'(credits), 32'd3);
        credit_in = 1'b1;
        tick;
        credit_in = 1'b0;
        check("ret_consume_3", 32'(credits), 32'd3);
        tail = 5'b10000; req = 5'b11111;
        #1 check("tail_grant", 32'(grant), 32'h10);
        tick;
        tail = 5'b0;
        check("after_tail_xbar",    32'(xbar_sel), 32'h00);
        check("after_tail_grant",   32'(grant), 32'h00);
        check("after_tail_credits", 32'(credits), 32'd2);
        tick;
        check("rr_N_xbar", 32'(xbar_sel), 32'h01);
        tail = 5'b00001;
        #1 check("rr_N_grant", 32'(grant), 32'h01);
        tick;
        tail = 5'b0;
        check("N_done_credits", 32'(credits), 32'd1);
        check("N_done_xbar",    32'(xbar_sel), 32'h00);
        tick;
        check("rr_E_xbar", 32'(xbar_sel), 32'h02);

        req = 5'b11101;
        #1 check("hold_no_grant", 32'(grant), 32'h00);
        check("hold_xbar", 32'(xbar_sel), 32'h02);
        credit_in = 1'b1;
        repeat (3) tick;
        check("refill_credits", 32'(credits), 32'd4);
        check("hold_xbar2", 32'(xbar_sel), 32'h02);
        tick;
        credit_in = 1'b0;
        check("ovf_credits", 32'(credits), 32'd4);
        check("ovf_err", 32'(credit_err), 32'd1);
        tick;
        check("ovf_err_clear", 32'(credit_err), 32'd0);

        req = 5'b11111;
        #1 check("E_resume_grant", 32'(grant), 32'h02);
        for (int c = 3; c >= 0; c--) begin
            tick;
            check("stream_credits", 32'(credits), 32'(c));
        end
        check("starve_grant", 32'(grant), 32'h00);
        check("starve_xbar",  32'(xbar_sel), 32'h02);
        tick;
        check("starve_hold", 32'(grant), 32'h00);
        credit_in = 1'b1;
        #1 check("credit_cycle_grant", 32'(grant), 32'h00);
        tick;
        credit_in = 1'b0;
        check("after_credit_credits", 32'(credits), 32'd1);
        check("after_credit_grant",   32'(grant), 32'h02);

        req = 5'b11101; credit_in = 1'b1;
        tick;
        credit_in = 1'b0;
        check("return_to_2", 32'(credits), 32'd2);
        req = 5'b11111; credit_in = 1'b1;
        #1 check("both_grant", 32'(grant), 32'h02);
        tick;
        credit_in = 1'b0;
        check("ret_consume_2", 32'(credits), 32'd2);
        tick;
        check("pre_rst_credits", 32'(credits), 32'd1);
        check("pre_rst_xbar",    32'(xbar_sel), 32'h02);

        rst = 1'b1;
        #1;
        check("mid_rst_grant",   32'(grant), 32'h00);
        check("mid_rst_xbar",    32'(xbar_sel), 32'h00);
        check("mid_rst_credits", 32'(credits), 32'd4);
        tick;
        rst = 1'b0; req = 5'b11111;
        tick;
        check("post_rst_ptr_L", 32'(xbar_sel), 32'h10);
        check("post_rst_grant", 32'(grant), 32'h10);

        req = 5'b01111;
        #1 check("L_drop_grant", 32'(grant), 32'h00);
`ifdef ARB_TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (!timeout_err && n < 40) begin
                tick;
                n++;
            end
            check("timeout_cycles", 32'(n), 32'd16);
            check("timeout_release_xbar", 32'(xbar_sel), 32'h00);
            tick;
            check("timeout_err_clear", 32'(timeout_err), 32'd0);
            check("waiting_N_xbar", 32'(xbar_sel), 32'h01);
        end
`else
        repeat (24) tick;
        check("lock_persist_xbar",  32'(xbar_sel), 32'h10);
        check("lock_persist_grant", 32'(grant), 32'h00);
        check("no_timeout_err",     32'(timeout_err), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
